// File: rtl/maf_pkg.sv
// maf_pkg: shared format/cont encodings and completion-ownership type for the MAF shift scheduler
package maf_pkg;
  localparam logic [1:0] FMT_WIDE   = 2'b00;
  localparam logic [1:0] FMT_DUAL   = 2'b01;
  localparam logic [1:0] FMT_BYPASS = 2'b10;
  localparam logic [1:0] FMT_ILL    = 2'b11;
  localparam logic [2:0] CONT_WIDE  = 3'b000;
  localparam logic [2:0] CONT_DUAL  = 3'b001;
  localparam logic [2:0] CONT_PASS  = 3'b010;
  typedef struct packed {
    logic a;
    logic b;
  } cpl_own_t;
endpackage

// File: rtl/maf_cpl_fifo.sv
// maf_cpl_fifo: synchronous FIFO with occupancy count; caller guarantees no overflow or underflow
module maf_cpl_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/maf_shift_sched.sv
// maf_shift_sched: two-lane arbiter/packer driving the MAF alignment shifter with tagged completion routing
module maf_shift_sched
  import maf_pkg::*;
#(
  parameter int TAG_W        = 3,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              a_valid,
  output logic                              a_ready,
  input  logic [1:0]                        a_fmt,
  input  logic                              a_sh,
  input  logic [TAG_W-1:0]                  a_tag,
  input  logic                              b_valid,
  output logic                              b_ready,
  input  logic [1:0]                        b_fmt,
  input  logic                              b_sh,
  input  logic [TAG_W-1:0]                  b_tag,
  output logic                              iss_valid,
  input  logic                              iss_ready,
  output logic [2:0]                        iss_cont,
  output logic [11:0]                       iss_d,
  input  logic                              cmp_valid,
  output logic                              rsp_a_valid,
  output logic                              rsp_b_valid,
  output logic [TAG_W-1:0]                  rsp_a_tag,
  output logic [TAG_W-1:0]                  rsp_b_tag,
  output logic [$clog2(MAX_INFLIGHT):0]     inflight,
  output logic                              err
);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  typedef struct packed {
    cpl_own_t         own;
    logic [TAG_W-1:0] a_tag;
    logic [TAG_W-1:0] b_tag;
  } cpl_t;
  logic       rr, load_en, pack, load, pop, empty, bad;
  logic [1:0] g_fmt, d_q, nxt_d;
  logic       g_sh;
  logic [2:0] nxt_cont;
  cpl_t       push_e, head;
  // credits count only registered occupancy, so a same-cycle completion cannot unblock a grant
  assign load_en = (!iss_valid || iss_ready) && (inflight < CW'(MAX_INFLIGHT));
  assign pack    = a_valid && b_valid && a_fmt == FMT_DUAL && b_fmt == FMT_DUAL;
  assign a_ready = load_en && a_valid && (pack || !b_valid || !rr);
  assign b_ready = load_en && b_valid && (pack || !a_valid || rr);
  assign load    = a_ready || b_ready;
  assign empty   = inflight == '0;
  assign pop     = cmp_valid && !empty;
  assign push_e  = {a_ready, b_ready, a_tag, b_tag};
  assign iss_d   = {10'b0, d_q};
  always_comb begin
    g_fmt    = a_ready ? a_fmt : b_fmt;
    g_sh     = a_ready ? a_sh : b_sh;
    nxt_cont = g_fmt == FMT_WIDE ? CONT_WIDE : g_fmt == FMT_DUAL ? CONT_DUAL : CONT_PASS;
    nxt_d    = pack ? {b_sh, a_sh} :
               g_fmt == FMT_WIDE ? {1'b0, g_sh} :
               g_fmt == FMT_DUAL ? (a_ready ? {1'b0, a_sh} : {b_sh, 1'b0}) : 2'b00;
    bad      = (a_ready && a_fmt == FMT_ILL) || (b_ready && b_fmt == FMT_ILL);
  end
  maf_cpl_fifo #(.DEPTH(MAX_INFLIGHT), .W($bits(cpl_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (load),
    .pop   (pop),
    .din   (push_e),
    .dout  (head),
    .count (inflight)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr          <= 1'b0;
      iss_valid   <= 1'b0;
      iss_cont    <= CONT_WIDE;
      d_q         <= '0;
      rsp_a_valid <= 1'b0;
      rsp_b_valid <= 1'b0;
      rsp_a_tag   <= '0;
      rsp_b_tag   <= '0;
      err         <= 1'b0;
    end else begin
      if (a_ready ^ b_ready) rr <= a_ready;
      if (load) begin
        iss_valid <= 1'b1;
        iss_cont  <= nxt_cont;
        d_q       <= nxt_d;
      end else if (iss_ready) iss_valid <= 1'b0;
      rsp_a_valid <= pop && head.own.a;
      rsp_b_valid <= pop && head.own.b;
      if (pop) begin
        rsp_a_tag <= head.a_tag;
        rsp_b_tag <= head.b_tag;
      end
      if (bad || (cmp_valid && empty)) err <= 1'b1;
    end
endmodule

// File: tb/tb_maf_shift_sched.sv
// tb_maf_shift_sched: randomized + directed scoreboard bench against a queue-based reference model
module tb_maf_shift_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 0, b_valid = 0, a_sh = 0, b_sh = 0, iss_ready = 0, cmp_valid = 0;
  logic [1:0] a_fmt = 0, b_fmt = 0;
  logic [2:0] a_tag = 0, b_tag = 0;
  logic       a_ready, b_ready, iss_valid, rsp_a_valid, rsp_b_valid, err;
  logic [2:0] iss_cont, rsp_a_tag, rsp_b_tag, inflight;
  logic [11:0] iss_d;

  always #5 clk = ~clk;

  maf_shift_sched #(.TAG_W(3), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_fmt(a_fmt), .a_sh(a_sh), .a_tag(a_tag),
    .b_valid(b_valid), .b_ready(b_ready), .b_fmt(b_fmt), .b_sh(b_sh), .b_tag(b_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_cont(iss_cont), .iss_d(iss_d),
    .cmp_valid(cmp_valid),
    .rsp_a_valid(rsp_a_valid), .rsp_b_valid(rsp_b_valid),
    .rsp_a_tag(rsp_a_tag), .rsp_b_tag(rsp_b_tag),
    .inflight(inflight), .err(err)
  );

  typedef struct {
    int         c;
    logic       a;
    logic       b;
    logic [2:0] ta;
    logic [2:0] tb;
  } rsp_t;

  int          n_chk = 0, n_fail = 0, cyc = 0;
  logic [14:0] exp_iss[$];
  rsp_t        exp_rsp[$];
  rsp_t        m_cpl[$];
  logic        m_pend = 0, m_err = 0, m_rr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // expected {cont, d} for a single-lane op
  function automatic logic [14:0] enc(input logic [1:0] f, input logic sh, input logic side_b);
    case (f)
      2'b00:   return {3'b000, 12'(sh)};
      2'b01:   return {3'b001, side_b ? (12'(sh) << 1) : 12'(sh)};
      default: return {3'b010, 12'd0};
    endcase
  endfunction

  task automatic step(input logic av, input logic [1:0] af, input logic ash, input logic [2:0] at,
                      input logic bv, input logic [1:0] bf, input logic bsh, input logic [2:0] bt,
                      input logic ir, input logic cv);
    logic can, pk, ga, gb;
    rsp_t o;
    @(posedge clk);
    #1;
    cyc++;
    chk("iss_valid", 32'(iss_valid), 32'(m_pend));
    chk("inflight", 32'(inflight), 32'(m_cpl.size()));
    chk("err", 32'(err), 32'(m_err));
    a_valid = av; a_fmt = af; a_sh = ash; a_tag = at;
    b_valid = bv; b_fmt = bf; b_sh = bsh; b_tag = bt;
    iss_ready = ir; cmp_valid = cv;
    #1;
    can = (!m_pend || ir) && m_cpl.size() < 4;
    pk  = av && bv && af == 2'b01 && bf == 2'b01;
    ga = 0; gb = 0;
    if (can) begin
      if (pk) begin ga = 1; gb = 1; end
      else if (av && bv) begin if (m_rr) gb = 1; else ga = 1; end
      else begin ga = av; gb = bv; end
    end
    chk("a_ready", 32'(a_ready), 32'(ga));
    chk("b_ready", 32'(b_ready), 32'(gb));
    if (cv) begin
      if (m_cpl.size() > 0) begin
        o = m_cpl.pop_front();
        o.c = cyc + 1;
        exp_rsp.push_back(o);
      end else m_err = 1;
    end
    if (ga || gb) begin
      exp_iss.push_back(pk ? {3'b001, 12'({bsh, ash})} : ga ? enc(af, ash, 1'b0) : enc(bf, bsh, 1'b1));
      m_cpl.push_back('{0, ga, gb, at, bt});
      m_pend = 1;
      if ((ga && af == 2'b11) || (gb && bf == 2'b11)) m_err = 1;
      if (!pk) m_rr = ga;
    end else if (ir) m_pend = 0;
  endtask

  task automatic idle(input logic ir, input logic cv);
    step(0, 2'd0, 0, 3'd0, 0, 2'd0, 0, 3'd0, ir, cv);
  endtask

  task automatic rnd(input logic ill, input logic cmp_any);
    step(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, ill ? 3 : 2)), 1'($urandom), 3'($urandom),
         1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, ill ? 3 : 2)), 1'($urandom), 3'($urandom),
         1'($urandom_range(0, 3) != 0),
         cmp_any ? 1'($urandom) : 1'(m_cpl.size() > 0 && $urandom_range(0, 1) == 1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 0;
    a_valid = 0; b_valid = 0; iss_ready = 0; cmp_valid = 0;
    #1;
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_iss_cont", 32'(iss_cont), 0);
    chk("rst_iss_d", 32'(iss_d), 0);
    chk("rst_rsp", 32'({rsp_a_valid, rsp_b_valid}), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_err", 32'(err), 0);
    m_cpl.delete(); exp_iss.delete(); exp_rsp.delete();
    m_pend = 0; m_err = 0; m_rr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // scoreboard monitor: consumes expectations whenever the DUT presents an issue handshake or a response
  always @(negedge clk) begin
    if (rst_n) begin
      if (iss_valid && iss_ready) begin
        if (exp_iss.size() == 0) chk("iss_unexpected", 32'({iss_cont, iss_d}), 32'h7fff);
        else chk("iss_ctrl", 32'({iss_cont, iss_d}), 32'(exp_iss.pop_front()));
      end
      if (rsp_a_valid || rsp_b_valid) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'({rsp_a_valid, rsp_b_valid}), 0);
        else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(r.c));
          chk("rsp", 32'({rsp_a_valid, rsp_b_valid, rsp_a_valid ? rsp_a_tag : 3'd0, rsp_b_valid ? rsp_b_tag : 3'd0}),
              32'({r.a, r.b, r.a ? r.ta : 3'd0, r.b ? r.tb : 3'd0}));
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    do_reset();
    // packed dual issue, then its completion
    step(1, 2'b01, 1, 3'd2, 1, 2'b01, 1, 3'd5, 1, 0);
    idle(1, 0);
    idle(1, 1);
    idle(1, 0);
    // both WIDE held valid: alternate A/B
    for (int i = 0; i < 8; i++)
      step(1, 2'b00, 1'($urandom), 3'(i), 1, 2'b00, 1'($urandom), 3'(7 - i), 1, 1'(m_cpl.size() > 0));
    repeat (6) idle(1, 1'(m_cpl.size() > 0));
    // stall with a pending issue
    step(1, 2'b00, 1, 3'd3, 0, 2'd0, 0, 3'd0, 1, 0);
    repeat (3) step(1, 2'b01, 1, 3'd4, 1, 2'b10, 0, 3'd6, 0, 0);
    step(1, 2'b01, 1, 3'd4, 1, 2'b10, 0, 3'd6, 1, 0);
    repeat (6) idle(1, 1'(m_cpl.size() > 0));
    // fill all credits, then complete alongside a new request
    for (int i = 0; i < 4; i++) step(1, 2'b00, 1, 3'(i), 0, 2'd0, 0, 3'd0, 1, 0);
    step(0, 2'd0, 0, 3'd0, 1, 2'b01, 1, 3'd1, 1, 1);
    step(0, 2'd0, 0, 3'd0, 1, 2'b01, 1, 3'd1, 1, 0);
    repeat (8) idle(1, 1'(m_cpl.size() > 0));
    repeat (300) rnd(0, 0);
    repeat (8) idle(1, 1'(m_cpl.size() > 0));
    // illegal format, then completion on an empty FIFO
    step(1, 2'b11, 1, 3'd1, 0, 2'd0, 0, 3'd0, 1, 0);
    repeat (6) idle(1, 1);
    // reset with ops in flight
    step(1, 2'b00, 1, 3'd1, 0, 2'd0, 0, 3'd0, 1, 0);
    step(0, 2'd0, 0, 3'd0, 1, 2'b00, 1, 3'd2, 1, 0);
    do_reset();
    step(1, 2'b01, 1, 3'd3, 0, 2'd0, 0, 3'd0, 1, 0);
    repeat (4) idle(1, 1'(m_cpl.size() > 0));
    repeat (300) rnd(1, 1);
    repeat (10) idle(1, 1);
    @(negedge clk);
    #1;
    chk("iss_drained", 32'(exp_iss.size()), 0);
    chk("rsp_drained", 32'(exp_rsp.size()), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
